// File: rtl/bin_act_packer.sv
// Packs NP-bit activation beats into PW-bit words and buffers them in a small FIFO.
// Words are dropped (sticky overflow) when the FIFO is full, since the input cannot stall.
module bin_act_packer #(
  parameter int NP         = 8,
  parameter int PW         = 8,
  parameter int N_NEURONS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [NP-1:0]                   in_y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PW-1:0]                   out_data,
  output logic                            out_last,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level
);

  localparam int BEATS = PW / NP;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NCW   = $clog2(N_NEURONS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic          last;
    logic [PW-1:0] data;
  } entry_t;

  logic [PW-1:0]  asm_q, asm_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [NCW-1:0] neuron_cnt_q, neuron_cnt_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  entry_t         mem_q [FIFO_DEPTH];
  entry_t         mem_d [FIFO_DEPTH];

  logic [PW-1:0]  merged;
  logic           word_done;
  logic           word_last;
  logic           pop;
  logic           push_ok;

  always_comb begin
    merged = asm_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt_q == BCW'(b)) begin
        merged[b*NP +: NP] = in_y;
      end
    end

    word_done = in_valid && (beat_cnt_q == BCW'(BEATS - 1));
    word_last = (neuron_cnt_q + NCW'(NP)) == NCW'(N_NEURONS);
    pop       = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    push_ok   = word_done && ((count_q != CW'(FIFO_DEPTH)) || pop);

    asm_d        = asm_q;
    beat_cnt_d   = beat_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;

    if (in_valid) begin
      neuron_cnt_d = word_last ? '0 : neuron_cnt_q + NCW'(NP);
      if (word_done) begin
        asm_d      = '0;
        beat_cnt_d = '0;
      end else begin
        asm_d      = merged;
        beat_cnt_d = beat_cnt_q + BCW'(1);
      end
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = '{last: word_last, data: merged};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (word_done) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q        <= '0;
      beat_cnt_q   <= '0;
      neuron_cnt_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      beat_cnt_q   <= beat_cnt_d;
      neuron_cnt_q <= neuron_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q].data : '0;
    out_last   = out_valid ? mem_q[rd_ptr_q].last : 1'b0;
    overflow   = overflow_q;
    fill_level = count_q;
  end

endmodule

// File: tb/tb_bin_act_packer.sv
// Scoreboard bench for bin_act_packer: two instances (NP=8 and NP=4) share one stimulus
// stream; a bit-accumulating reference model predicts words, occupancy and overflow.
module tb_bin_act_packer;

  localparam int D    = 4;
  localparam int NP_A = 8;
  localparam int PW_A = 8;
  localparam int N_A  = 64;
  localparam int NP_B = 4;
  localparam int PW_B = 8;
  localparam int N_B  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_y = '0;

  logic       va, la, oa;
  logic [7:0] da;
  logic [2:0] fa;
  logic       vb, lb, ob;
  logic [7:0] db;
  logic [2:0] fb;

  bin_act_packer #(.NP(NP_A), .PW(PW_A), .N_NEURONS(N_A), .FIFO_DEPTH(D)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y),
    .out_valid(va), .out_ready(out_ready), .out_data(da), .out_last(la),
    .overflow(oa), .fill_level(fa)
  );

  bin_act_packer #(.NP(NP_B), .PW(PW_B), .N_NEURONS(N_B), .FIFO_DEPTH(D)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y[3:0]),
    .out_valid(vb), .out_ready(out_ready), .out_data(db), .out_last(lb),
    .overflow(ob), .fill_level(fb)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int         cnt   [2];
  bit         ovf   [2];
  int         part  [2];
  int         nbits [2];
  int         img   [2];
  logic [8:0] sb_a [$];
  logic [8:0] sb_b [$];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i]   = 0;
      ovf[i]   = 1'b0;
      part[i]  = 0;
      nbits[i] = 0;
      img[i]   = 0;
    end
    sb_a.delete();
    sb_b.delete();
  endtask

  // Append NP activation bits to the current word; a word is complete once it holds PW bits.
  task automatic model_inst(input int i, input int np, input int pw, input int n,
                            input logic v, input logic [7:0] y, input logic rdy);
    bit         pop;
    bit         done;
    logic [8:0] w;
    pop  = (cnt[i] > 0) && rdy;
    done = 1'b0;
    w    = '0;
    if (v) begin
      part[i]  = part[i] | ((int'(y) & ((1 << np) - 1)) << nbits[i]);
      nbits[i] = nbits[i] + np;
      img[i]   = img[i] + np;
      if (nbits[i] == pw) begin
        w        = {(img[i] == n) ? 1'b1 : 1'b0, 8'(part[i])};
        part[i]  = 0;
        nbits[i] = 0;
        done     = 1'b1;
      end
      if (img[i] == n) img[i] = 0;
      if (done) begin
        if (cnt[i] < D || pop) begin
          if (i == 0) sb_a.push_back(w);
          else        sb_b.push_back(w);
          cnt[i] = cnt[i] + 1;
        end else begin
          ovf[i] = 1'b1;
        end
      end
    end
    if (pop) cnt[i] = cnt[i] - 1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] y, input logic rdy);
    in_valid  = v;
    in_y      = y;
    out_ready = rdy;
    @(posedge clk);
    model_inst(0, NP_A, PW_A, N_A, v, y, rdy);
    model_inst(1, NP_B, PW_B, N_B, v, y, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, rdy);
  endtask

  // Monitor: compares DUT outputs against the model and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    logic [8:0] exp_w;
    if (mon_en) begin
      check("fill_a", int'(fa), cnt[0]);
      check("ovf_a", int'(oa), int'(ovf[0]));
      check("valid_a", int'(va), (cnt[0] != 0) ? 1 : 0);
      if (va && out_ready) begin
        if (sb_a.size() == 0) check("sb_a_has_entry", 0, 1);
        else begin
          exp_w = sb_a.pop_front();
          check("word_a", int'({la, da}), int'(exp_w));
        end
      end else if (!va) begin
        check("idle_a", int'({la, da}), 0);
      end

      check("fill_b", int'(fb), cnt[1]);
      check("ovf_b", int'(ob), int'(ovf[1]));
      check("valid_b", int'(vb), (cnt[1] != 0) ? 1 : 0);
      if (vb && out_ready) begin
        if (sb_b.size() == 0) check("sb_b_has_entry", 0, 1);
        else begin
          exp_w = sb_b.pop_front();
          check("word_b", int'({lb, db}), int'(exp_w));
        end
      end else if (!vb) begin
        check("idle_b", int'({lb, db}), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    mon_en = 1'b1;

    // Ascending beats, consumer always ready; last flag on the final word only.
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 8'(k), 1'b1);
    idle(3, 1'b1);

    // Two nibble beats form one word in B; a lone third beat must not produce one.
    applyStimulus(1'b1, 8'h0A, 1'b1);
    applyStimulus(1'b1, 8'h05, 1'b1);
    applyStimulus(1'b1, 8'h0F, 1'b1);
    idle(3, 1'b1);
    check("t2_no_word_b", int'(vb), 0);

    // Overflow: five words into a four-entry FIFO with the consumer stalled.
    do_reset();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    idle(1, 1'b0);
    check("t3_fill_a", int'(fa), 4);
    check("t3_ovf_a", int'(oa), 1);
    idle(6, 1'b1);
    check("t3_drained_a", int'(va), 0);

    // Full FIFO with simultaneous pop and completing push: no overflow.
    do_reset();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1);
    idle(1, 1'b0);
    check("t4_fill_a", int'(fa), 4);
    check("t4_ovf_a", int'(oa), 0);
    idle(6, 1'b1);

    // Two images back to back.
    do_reset();
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    idle(3, 1'b1);

    // Reset mid-image with words buffered, then a clean image.
    do_reset();
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    idle(1, 1'b0);
    check("t6_ovf_pre", int'(oa), 0);
    do_reset();
    check("t6_valid_a", int'(va), 0);
    check("t6_fill_a", int'(fa), 0);
    check("t6_ovf_a", int'(oa), 0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with varying consumer throughput and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 149) == 0) do_reset();
        else applyStimulus($urandom_range(0, 9) < 7, 8'($urandom),
                           $urandom_range(1, 100) <= rdy_pct);
      end
    end

    idle(12, 1'b1);
    check("final_sb_a_empty", sb_a.size(), 0);
    check("final_sb_b_empty", sb_b.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
